dmem_port_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port data memory (256 x 32-bit words).
- The memory has one access port. Write and read are both sampled on the CLK edge. Read data is registered, so it is valid one cycle after issue.
- Port 0 is the CPU load/store stage, with default priority. Port 1 is the debug/program-loader path, protected by a starvation guard.
- The arbiter issues at most one access per cycle, routes the read data back to the owning port, and issues back-to-back accesses with no bubble.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_starve_ctr.sv | 40 ++++
 rtl/dmem_port_arbiter.sv | 96 +++++++++
 tb/tb_dmem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: port indices,
// starvation counter width and the per-port request bundle.
package dmem_arb_pkg;

  localparam int PORT_CPU   = 0;
  localparam int PORT_DBG   = 1;
  localparam int STARVE_W   = 4;
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } port_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive cycles the debug port is refused while requesting and
// flags when it must be given priority on the next opportunity.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic p1_req,
  input  logic p1_gnt,
  output logic force1
);

  localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_reg;
  logic [STARVE_W-1:0] cnt_next;

  // A grant or a withdrawn request both clear the debt; refusals saturate.
  always_comb begin
    cnt_next = cnt_reg;
    if (p1_gnt || !p1_req) begin
      cnt_next = '0;
    end else if (cnt_reg < LIMIT_V) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign force1 = (cnt_reg >= LIMIT_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory: fixed CPU priority
// with a starvation guard for the debug port, and tagged read-data return.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  port_req_t p0;
  port_req_t p1;
  port_req_t win;
  logic      force1;
  logic      any_gnt;
  logic      rd_issue;
  logic      rsp_valid_reg;
  logic      rsp_port_reg;

  assign p0 = '{req: p0_req, we: p0_we,
                addr: REQ_ADDR_W'(p0_addr), wdata: REQ_DATA_W'(p0_wdata)};
  assign p1 = '{req: p1_req, we: p1_we,
                addr: REQ_ADDR_W'(p1_addr), wdata: REQ_DATA_W'(p1_wdata)};

  dmem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk    (CLK),
    .srst   (RST),
    .p1_req (p1_req),
    .p1_gnt (p1_gnt),
    .force1 (force1)
  );

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!RST) begin
      if (force1) begin
        p1_gnt = p1.req;
        p0_gnt = p0.req & ~p1.req;
      end else begin
        p0_gnt = p0.req;
        p1_gnt = p1.req & ~p0.req;
      end
    end
  end

  // Port 0 drives the memory bus whenever port 1 is not the winner.
  assign win       = p1_gnt ? p1 : p0;
  assign any_gnt   = p0_gnt | p1_gnt;
  assign rd_issue  = any_gnt & win.req & ~win.we;
  assign mem_we    = any_gnt & win.req & win.we;
  assign mem_addr  = ADDR_W'(win.addr);
  assign mem_wdata = DATA_W'(win.wdata);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid_reg <= 1'b0;
      rsp_port_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= rd_issue;
      if (rd_issue) begin
        rsp_port_reg <= p1_gnt ? 1'(PORT_DBG) : 1'(PORT_CPU);
      end
    end
  end

  // A response still in flight when reset arrives is never presented.
  assign p0_rvalid = ~RST & rsp_valid_reg & (rsp_port_reg == 1'(PORT_CPU));
  assign p1_rvalid = ~RST & rsp_valid_reg & (rsp_port_reg == 1'(PORT_DBG));
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations
// followed by random traffic compared every cycle against a reference model.
module tb_dmem_port_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  dmem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:       init_val = 32'h0000_0011;
      2:       init_val = 32'h0000_0022;
      3:       init_val = 32'h0000_0033;
      5:       init_val = 32'hA5A5_A5A5;
      default: init_val = 32'h0101_0101 * i;
    endcase
  endfunction

  // Single-port memory with registered read, driven by the DUT's bus.
  logic [31:0] bmem [256];
  bit          bmem_init = 1'b0;
  always @(posedge CLK) begin
    if (!bmem_init) begin
      for (int i = 0; i < 256; i++) bmem[i] <= init_val(i);
      bmem_init <= 1'b1;
    end else begin
      if (mem_we) bmem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= bmem[mem_addr[7:0]];
    end
  end

  int cmp_count  = 0;
  int fail_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents, who owes a response, and refused-cycle run of port 1.
  logic [31:0] ref_mem [256];
  bit          ref_init = 1'b0;
  int          denied   = 0;
  bit          m_valid  = 1'b0;
  bit          m_port   = 1'b0;
  logic [31:0] m_data;
  int          m_win;
  logic        m_we;
  logic [31:0] m_addr, m_wd;

  always @(negedge CLK) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (RST) begin
      check("rst_p0_gnt", p0_gnt, 0);
      check("rst_p1_gnt", p1_gnt, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_p0_rvalid", p0_rvalid, 0);
      check("rst_p1_rvalid", p1_rvalid, 0);
      denied  = 0;
      m_valid = 1'b0;
    end else begin
      check("p0_rvalid", p0_rvalid, m_valid && !m_port);
      check("p1_rvalid", p1_rvalid, m_valid && m_port);
      if (m_valid && !m_port) check("p0_rdata", p0_rdata, m_data);
      if (m_valid && m_port)  check("p1_rdata", p1_rdata, m_data);
      if (denied >= LIMIT) m_win = p1_req ? 1 : (p0_req ? 0 : -1);
      else                 m_win = p0_req ? 0 : (p1_req ? 1 : -1);
      check("p0_gnt", p0_gnt, m_win == 0);
      check("p1_gnt", p1_gnt, m_win == 1);
      m_we   = (m_win == 1) ? p1_we    : p0_we;
      m_addr = (m_win == 1) ? p1_addr  : p0_addr;
      m_wd   = (m_win == 1) ? p1_wdata : p0_wdata;
      check("mem_we", mem_we, (m_win >= 0) && m_we);
      m_valid = 1'b0;
      if (m_win >= 0) begin
        check("mem_addr", mem_addr, m_addr);
        if (m_we) begin
          check("mem_wdata", mem_wdata, m_wd);
          ref_mem[m_addr[7:0]] = m_wd;
        end else begin
          m_valid = 1'b1;
          m_port  = (m_win == 1);
          m_data  = ref_mem[m_addr[7:0]];
        end
      end
      if (m_win == 1 || !p1_req) denied = 0;
      else if (denied < LIMIT)   denied = denied + 1;
    end
  end

  task automatic set_ports(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  logic [14:0] pat;
  logic [8:0]  pat5;
  bit          g0, g1;

  initial begin
    RST = 1'b1;
    set_ports(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle;
    RST = 1'b0;
    #2;
    check("reset_p0_gnt", p0_gnt, 0);
    check("reset_p0_rvalid", p0_rvalid, 0);
    check("reset_p1_rvalid", p1_rvalid, 0);
    check("reset_mem_we", mem_we, 0);

    // p0 read of address 5
    next_cycle; set_ports(1, 0, 5, 0, 0, 0, 0, 0); #2;
    check("t1_p0_gnt", p0_gnt, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 5);
    next_cycle; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("t1_p0_rvalid", p0_rvalid, 1);
    check("t1_p0_rdata", p0_rdata, 32'hA5A5_A5A5);
    check("t1_p1_rvalid", p1_rvalid, 0);
    $display("directed: p0 read addr 5 done");

    // p1 write then p0 read of the same address
    next_cycle; set_ports(0, 0, 0, 0, 1, 1, 9, 32'h1234); #2;
    check("t2_p1_gnt", p1_gnt, 1);
    check("t2_mem_we", mem_we, 1);
    next_cycle; set_ports(1, 0, 9, 0, 0, 0, 0, 0); #2;
    check("t2_p0_gnt", p0_gnt, 1);
    next_cycle; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("t2_p0_rvalid", p0_rvalid, 1);
    check("t2_p0_rdata", p0_rdata, 32'h1234);
    check("t2_p1_rvalid", p1_rvalid, 0);
    $display("directed: p1 write / p0 read addr 9 done");

    // continuous contention
    for (int c = 0; c < 15; c++) begin
      next_cycle; set_ports(1, 0, 1, 0, 1, 0, 2, 0); #2;
      pat[c] = p1_gnt;
      if (p0_gnt && p1_gnt) check("t3_exclusive", 1, 0);
    end
    check("t3_force_pattern", {17'd0, pat}, 32'h0000_4210);
    next_cycle; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    $display("directed: contention pattern done");

    // back-to-back reads across both ports
    next_cycle; set_ports(1, 0, 1, 0, 0, 0, 0, 0); #2;
    next_cycle; set_ports(0, 0, 0, 0, 1, 0, 2, 0); #2;
    check("t4_rv0_a", p0_rvalid, 1);
    check("t4_rd0_a", p0_rdata, 32'h11);
    next_cycle; set_ports(1, 0, 3, 0, 0, 0, 0, 0); #2;
    check("t4_rv1_b", p1_rvalid, 1);
    check("t4_rd1_b", p1_rdata, 32'h22);
    next_cycle; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("t4_rv0_c", p0_rvalid, 1);
    check("t4_rd0_c", p0_rdata, 32'h33);
    $display("directed: back-to-back reads done");

    // p1 withdraws while starved: debt cleared
    for (int c = 0; c < 9; c++) begin
      next_cycle; set_ports(1, 0, 4, 0, (c != 3), 0, 6, 0); #2;
      pat5[c] = p1_gnt;
    end
    check("t5_restart_pattern", {23'd0, pat5}, 32'h0000_0100);
    next_cycle; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    $display("directed: starvation restart done");

    // reset right after a read grant
    next_cycle; set_ports(1, 0, 5, 0, 0, 0, 0, 0); #2;
    check("t6_p0_gnt", p0_gnt, 1);
    next_cycle; RST = 1'b1; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("t6_rvalid_in_rst", p0_rvalid, 0);
    next_cycle; RST = 1'b0; #2;
    check("t6_rvalid_after_rst", p0_rvalid, 0);
    next_cycle; set_ports(1, 0, 5, 0, 0, 0, 0, 0); #2;
    check("t6_regrant", p0_gnt, 1);
    next_cycle; set_ports(0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("t6_rvalid", p0_rvalid, 1);
    check("t6_rdata", p0_rdata, 32'hA5A5_A5A5);
    $display("directed: reset discard done");

    // random traffic, requests held until granted
    g0 = 1'b1; g1 = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      next_cycle;
      RST = ($urandom_range(0, 149) == 0);
      if (!p0_req || g0) begin
        p0_req   = ($urandom_range(0, 2) != 0);
        p0_we    = $urandom_range(0, 1);
        p0_addr  = $urandom_range(0, 15);
        p0_wdata = $urandom;
      end
      if (!p1_req || g1) begin
        p1_req   = ($urandom_range(0, 1) != 0);
        p1_we    = $urandom_range(0, 1);
        p1_addr  = $urandom_range(0, 15);
        p1_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        p1_req = 1'b0;
      end
      #2;
      g0 = p0_gnt;
      g1 = p1_gnt;
    end
    next_cycle; RST = 1'b0; set_ports(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle;
    $display("random: 3000 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
